// File: rtl/axi4_delayer_pkg.sv
// Shared types and sizing helpers for the AXI4 timed response delayer.
package axi4_delayer_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ID_W   = 4;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 8;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int HALF  = 2 ** (DEF_CNT_W - 1);

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_entry_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

  function automatic int ptr_w_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int half_of(input int cnt_w);
    return 2 ** (cnt_w - 1);
  endfunction

endpackage

// File: rtl/axi4_timed_delayer_delay_fifo.sv
// Timestamped FIFO: an entry is released once the shared timer reaches its stamp.
// Eligibility is sticky per slot so long stalls or timer wrap never revoke it.
module delay_fifo
  import axi4_delayer_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8,
  parameter int DELAY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] timer,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  output logic             full,
  input  logic             pop,
  output logic             head_valid,
  output logic [W-1:0]     head_data
);

  localparam int               PW       = ptr_w_of(DEPTH);
  localparam logic [CNT_W-1:0] HALF_N   = CNT_W'(half_of(CNT_W));
  localparam logic [CNT_W-1:0] DLY      = CNT_W'(DELAY);
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]     pay_mem   [DEPTH];
  logic [CNT_W-1:0] stamp_mem [DEPTH];
  logic [DEPTH-1:0] ripe_q;
  logic [DEPTH-1:0] ripe_now;
  logic [DEPTH-1:0] ripe_d;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Slot frees only on the following cycle, so full ignores a same-cycle pop.
  assign full       = (count == FULL_CNT);
  assign do_push    = push && !full;
  assign head_valid = (count != '0) && (ripe_q[rd_ptr] || ripe_now[rd_ptr]);
  assign do_pop     = pop && head_valid;
  assign head_data  = pay_mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ripe
    logic [CNT_W-1:0] age;
    assign age         = timer - stamp_mem[i];
    assign ripe_now[i] = (age < HALF_N);
  end

  always_comb begin
    ripe_d = ripe_q | ripe_now;
    if (do_push) begin
      ripe_d[wr_ptr] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ripe_q <= '0;
    end else begin
      ripe_q <= ripe_d;
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload and stamps are don't-care until written, so they carry no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      pay_mem[wr_ptr]   <= push_data;
      stamp_mem[wr_ptr] <= timer + DLY;
    end
  end

endmodule

// File: rtl/axi4_timed_delayer.sv
// AXI4 shim: AR/AW/W pass straight through; R and B responses are held back by DELAY cycles.
module axi4_timed_delayer
  import axi4_delayer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DELAY  = 3,
  parameter int CNT_W  = DEF_CNT_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  // AR
  input  logic                in_arvalid,
  output logic                in_arready,
  input  logic [ID_W-1:0]     in_arid,
  input  logic [31:0]         in_araddr,
  input  logic [7:0]          in_arlen,
  input  logic [2:0]          in_arsize,
  input  logic [1:0]          in_arburst,
  output logic                out_arvalid,
  input  logic                out_arready,
  output logic [ID_W-1:0]     out_arid,
  output logic [31:0]         out_araddr,
  output logic [7:0]          out_arlen,
  output logic [2:0]          out_arsize,
  output logic [1:0]          out_arburst,
  // AW
  input  logic                in_awvalid,
  output logic                in_awready,
  input  logic [ID_W-1:0]     in_awid,
  input  logic [31:0]         in_awaddr,
  input  logic [7:0]          in_awlen,
  input  logic [2:0]          in_awsize,
  input  logic [1:0]          in_awburst,
  output logic                out_awvalid,
  input  logic                out_awready,
  output logic [ID_W-1:0]     out_awid,
  output logic [31:0]         out_awaddr,
  output logic [7:0]          out_awlen,
  output logic [2:0]          out_awsize,
  output logic [1:0]          out_awburst,
  // W
  input  logic                in_wvalid,
  output logic                in_wready,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wstrb,
  input  logic                in_wlast,
  output logic                out_wvalid,
  input  logic                out_wready,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [DATA_W/8-1:0] out_wstrb,
  output logic                out_wlast,
  // R
  output logic                in_rvalid,
  input  logic                in_rready,
  output logic [ID_W-1:0]     in_rid,
  output logic [DATA_W-1:0]   in_rdata,
  output logic [1:0]          in_rresp,
  output logic                in_rlast,
  input  logic                out_rvalid,
  output logic                out_rready,
  input  logic [ID_W-1:0]     out_rid,
  input  logic [DATA_W-1:0]   out_rdata,
  input  logic [1:0]          out_rresp,
  input  logic                out_rlast,
  // B
  output logic                in_bvalid,
  input  logic                in_bready,
  output logic [ID_W-1:0]     in_bid,
  output logic [1:0]          in_bresp,
  input  logic                out_bvalid,
  output logic                out_bready,
  input  logic [ID_W-1:0]     out_bid,
  input  logic [1:0]          out_bresp
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_beat_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_beat_t;

  assign out_arvalid = in_arvalid;
  assign in_arready  = out_arready;
  assign out_arid    = in_arid;
  assign out_araddr  = in_araddr;
  assign out_arlen   = in_arlen;
  assign out_arsize  = in_arsize;
  assign out_arburst = in_arburst;

  assign out_awvalid = in_awvalid;
  assign in_awready  = out_awready;
  assign out_awid    = in_awid;
  assign out_awaddr  = in_awaddr;
  assign out_awlen   = in_awlen;
  assign out_awsize  = in_awsize;
  assign out_awburst = in_awburst;

  assign out_wvalid = in_wvalid;
  assign in_wready  = out_wready;
  assign out_wdata  = in_wdata;
  assign out_wstrb  = in_wstrb;
  assign out_wlast  = in_wlast;

  if (BYPASS) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clock, reset};

    assign in_rvalid  = out_rvalid;
    assign out_rready = in_rready;
    assign in_rid     = out_rid;
    assign in_rdata   = out_rdata;
    assign in_rresp   = out_rresp;
    assign in_rlast   = out_rlast;

    assign in_bvalid  = out_bvalid;
    assign out_bready = in_bready;
    assign in_bid     = out_bid;
    assign in_bresp   = out_bresp;
  end else begin : g_delay
    logic [CNT_W-1:0] timer;
    r_beat_t          r_in;
    r_beat_t          r_out;
    b_beat_t          b_in;
    b_beat_t          b_out;
    logic             r_full;
    logic             b_full;

    // Free-running; stamps are compared modulo 2^CNT_W so wrap is harmless.
    always_ff @(posedge clock) begin
      if (reset) begin
        timer <= '0;
      end else begin
        timer <= timer + CNT_W'(1);
      end
    end

    assign r_in       = '{id: out_rid, data: out_rdata, resp: out_rresp, last: out_rlast};
    assign out_rready = !r_full;
    assign in_rid     = r_out.id;
    assign in_rdata   = r_out.data;
    assign in_rresp   = r_out.resp;
    assign in_rlast   = r_out.last;

    delay_fifo #(
      .W     ($bits(r_beat_t)),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .DELAY (DELAY)
    ) u_r_fifo (
      .clock      (clock),
      .reset      (reset),
      .timer      (timer),
      .push       (out_rvalid),
      .push_data  (r_in),
      .full       (r_full),
      .pop        (in_rready),
      .head_valid (in_rvalid),
      .head_data  (r_out)
    );

    assign b_in       = '{id: out_bid, resp: out_bresp};
    assign out_bready = !b_full;
    assign in_bid     = b_out.id;
    assign in_bresp   = b_out.resp;

    delay_fifo #(
      .W     ($bits(b_beat_t)),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .DELAY (DELAY)
    ) u_b_fifo (
      .clock      (clock),
      .reset      (reset),
      .timer      (timer),
      .push       (out_bvalid),
      .push_data  (b_in),
      .full       (b_full),
      .pop        (in_bready),
      .head_valid (in_bvalid),
      .head_data  (b_out)
    );
  end

endmodule

// File: tb/tb_axi4_timed_delayer.sv
// Directed bench for axi4_timed_delayer (DELAY=3, DEPTH=4, CNT_W=8) plus a BYPASS instance.
module tb_axi4_timed_delayer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [7:0] tmr = 8'd0;

  // Shared stimulus
  logic        in_arvalid, out_arready, in_awvalid, out_awready;
  logic [3:0]  in_arid, in_awid;
  logic [31:0] in_araddr, in_awaddr;
  logic [7:0]  in_arlen, in_awlen;
  logic [2:0]  in_arsize, in_awsize;
  logic [1:0]  in_arburst, in_awburst;
  logic        in_wvalid, out_wready, in_wlast;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        out_rvalid, in_rready, out_rlast;
  logic [3:0]  out_rid;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic        out_bvalid, in_bready;
  logic [3:0]  out_bid;
  logic [1:0]  out_bresp;

  // Delaying DUT outputs
  logic        in_arready, out_arvalid, in_awready, out_awvalid;
  logic [3:0]  out_arid, out_awid;
  logic [31:0] out_araddr, out_awaddr;
  logic [7:0]  out_arlen, out_awlen;
  logic [2:0]  out_arsize, out_awsize;
  logic [1:0]  out_arburst, out_awburst;
  logic        in_wready, out_wvalid, out_wlast;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic        in_rvalid, in_rlast, out_rready;
  logic [3:0]  in_rid;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_bvalid, out_bready;
  logic [3:0]  in_bid;
  logic [1:0]  in_bresp;

  // Bypass DUT outputs
  logic        x_in_arready, x_out_arvalid, x_in_awready, x_out_awvalid;
  logic [3:0]  x_out_arid, x_out_awid;
  logic [31:0] x_out_araddr, x_out_awaddr;
  logic [7:0]  x_out_arlen, x_out_awlen;
  logic [2:0]  x_out_arsize, x_out_awsize;
  logic [1:0]  x_out_arburst, x_out_awburst;
  logic        x_in_wready, x_out_wvalid, x_out_wlast;
  logic [31:0] x_out_wdata;
  logic [3:0]  x_out_wstrb;
  logic        x_in_rvalid, x_in_rlast, x_out_rready;
  logic [3:0]  x_in_rid;
  logic [31:0] x_in_rdata;
  logic [1:0]  x_in_rresp;
  logic        x_in_bvalid, x_out_bready;
  logic [3:0]  x_in_bid;
  logic [1:0]  x_in_bresp;

  axi4_timed_delayer #(
    .DATA_W(32), .ID_W(4), .DEPTH(4), .DELAY(3), .CNT_W(8), .BYPASS(1'b0)
  ) dut (
    .clock(clock), .reset(reset),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_arid(in_arid), .in_araddr(in_araddr),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_arid(out_arid), .out_araddr(out_araddr),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awid(in_awid), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awid(out_awid), .out_awaddr(out_awaddr),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_wlast(out_wlast),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rid(in_rid), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .in_rlast(in_rlast), .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rid(out_rid),
    .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bid(in_bid), .in_bresp(in_bresp),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bid(out_bid), .out_bresp(out_bresp)
  );

  axi4_timed_delayer #(
    .DATA_W(32), .ID_W(4), .DEPTH(4), .DELAY(3), .CNT_W(8), .BYPASS(1'b1)
  ) dut_byp (
    .clock(clock), .reset(reset),
    .in_arvalid(in_arvalid), .in_arready(x_in_arready), .in_arid(in_arid), .in_araddr(in_araddr),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .out_arvalid(x_out_arvalid), .out_arready(out_arready), .out_arid(x_out_arid), .out_araddr(x_out_araddr),
    .out_arlen(x_out_arlen), .out_arsize(x_out_arsize), .out_arburst(x_out_arburst),
    .in_awvalid(in_awvalid), .in_awready(x_in_awready), .in_awid(in_awid), .in_awaddr(in_awaddr),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .out_awvalid(x_out_awvalid), .out_awready(out_awready), .out_awid(x_out_awid), .out_awaddr(x_out_awaddr),
    .out_awlen(x_out_awlen), .out_awsize(x_out_awsize), .out_awburst(x_out_awburst),
    .in_wvalid(in_wvalid), .in_wready(x_in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
    .out_wvalid(x_out_wvalid), .out_wready(out_wready), .out_wdata(x_out_wdata), .out_wstrb(x_out_wstrb),
    .out_wlast(x_out_wlast),
    .in_rvalid(x_in_rvalid), .in_rready(in_rready), .in_rid(x_in_rid), .in_rdata(x_in_rdata),
    .in_rresp(x_in_rresp), .in_rlast(x_in_rlast), .out_rvalid(out_rvalid), .out_rready(x_out_rready),
    .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
    .in_bvalid(x_in_bvalid), .in_bready(in_bready), .in_bid(x_in_bid), .in_bresp(x_in_bresp),
    .out_bvalid(out_bvalid), .out_bready(x_out_bready), .out_bid(out_bid), .out_bresp(out_bresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; tmr mirrors the DUT's free-running timer.
  task automatic tick();
    @(posedge clock);
    #1;
    tmr = tmr + 8'd1;
  endtask

  initial begin
    int   idx;
    int   rx;
    int   stable;
    int   seen;
    int   pop_cyc [5];
    logic acc;

    {in_arvalid, out_arready, in_awvalid, out_awready, in_wvalid, out_wready, in_wlast} = '0;
    {in_arid, in_awid, in_araddr, in_awaddr, in_arlen, in_awlen} = '0;
    {in_arsize, in_awsize, in_arburst, in_awburst, in_wdata, in_wstrb} = '0;
    {out_rvalid, in_rready, out_rlast, out_rid, out_rdata, out_rresp} = '0;
    {out_bvalid, in_bready, out_bid, out_bresp} = '0;
    for (int i = 0; i < 5; i++) pop_cyc[i] = 0;

    // Reset, then state in the first cycle after release
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tmr   = 8'd0;
    #1;
    chk("rst_in_rvalid", 64'(in_rvalid), 64'd0);
    chk("rst_in_bvalid", 64'(in_bvalid), 64'd0);
    chk("rst_out_rready", 64'(out_rready), 64'd1);
    chk("rst_out_bready", 64'(out_bready), 64'd1);

    // Request channels are combinational wires
    in_arvalid = 1'b1; in_arid = 4'h7; in_araddr = 32'h1000_0040; in_arlen = 8'd3; out_arready = 1'b1;
    in_awvalid = 1'b1; in_awaddr = 32'h2000_0080; out_awready = 1'b0;
    in_wvalid = 1'b1; in_wdata = 32'hCAFE_F00D; in_wstrb = 4'hC; out_wready = 1'b0;
    #1;
    chk("ar_valid", 64'(out_arvalid), 64'd1);
    chk("ar_addr", 64'(out_araddr), 64'h1000_0040);
    chk("ar_id", 64'(out_arid), 64'h7);
    chk("ar_len", 64'(out_arlen), 64'd3);
    chk("ar_ready", 64'(in_arready), 64'd1);
    chk("aw_addr", 64'(out_awaddr), 64'h2000_0080);
    chk("aw_ready", 64'(in_awready), 64'd0);
    chk("w_data", 64'(out_wdata), 64'hCAFE_F00D);
    chk("w_strb", 64'(out_wstrb), 64'hC);
    chk("w_ready", 64'(in_wready), 64'd0);
    in_arvalid = 1'b0; in_awvalid = 1'b0; in_wvalid = 1'b0;
    tick();

    // Single R beat appears exactly DELAY cycles after acceptance
    out_rvalid = 1'b1; out_rid = 4'h2; out_rdata = 32'hDEAD_BEEF; out_rresp = 2'b00; out_rlast = 1'b1;
    #1;
    chk("single_accept", 64'(out_rready), 64'd1);
    tick();
    out_rvalid = 1'b0; out_rlast = 1'b0;
    #1;
    chk("single_t1", 64'(in_rvalid), 64'd0);
    tick();
    #1;
    chk("single_t2", 64'(in_rvalid), 64'd0);
    tick();
    #1;
    chk("single_t3", 64'(in_rvalid), 64'd1);
    chk("single_id", 64'(in_rid), 64'h2);
    chk("single_data", 64'(in_rdata), 64'hDEAD_BEEF);
    chk("single_last", 64'(in_rlast), 64'd1);
    in_rready = 1'b1;
    tick();
    in_rready = 1'b0;
    #1;
    chk("single_popped", 64'(in_rvalid), 64'd0);

    // Four-beat burst with in_rready held high
    in_rready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      out_rvalid = (k < 4);
      out_rid    = 4'h3;
      out_rdata  = 32'hA000_0000 + 32'(k);
      out_rlast  = (k == 3);
      #1;
      chk("burst_vld", 64'(in_rvalid), 64'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) begin
        chk("burst_data", 64'(in_rdata), 64'(32'hA000_0000 + 32'(k - 3)));
        chk("burst_last", 64'(in_rlast), 64'(k == 6));
      end
      tick();
    end
    out_rvalid = 1'b0; out_rlast = 1'b0; in_rready = 1'b0;

    // Fill to DEPTH with upstream stalled; fifth beat must be held off
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      out_rvalid = 1'b1;
      out_rid    = 4'h4;
      out_rdata  = 32'hB000_0000 + 32'(idx);
      #1;
      chk("full_rdy", 64'(out_rready), 64'(k < 4));
      if (out_rready) idx++;
      tick();
    end
    chk("full_accepts", 64'(idx), 64'd4);

    in_rready = 1'b1;
    rx = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (n == 0) chk("pop_no_slot", 64'(out_rready), 64'd0);
      if (in_rvalid) begin
        chk("order", 64'(in_rdata), 64'(32'hB000_0000 + 32'(rx)));
        if (rx < 5) pop_cyc[rx] = n;
        rx++;
      end
      acc = out_rvalid && out_rready;
      tick();
      if (acc) out_rvalid = 1'b0;
    end
    in_rready = 1'b0; out_rvalid = 1'b0;
    chk("release_count", 64'(rx), 64'd5);
    chk("release_b2b", 64'(pop_cyc[4] - pop_cyc[0]), 64'd4);

    // B beat stamped across timer wrap, then a long stall
    in_bready = 1'b0;
    for (int n = 0; n < 300 && tmr != 8'd254; n++) tick();
    out_bvalid = 1'b1; out_bid = 4'h5; out_bresp = 2'b10;
    #1;
    chk("b_accept", 64'(out_bready), 64'd1);
    tick();
    out_bvalid = 1'b0;
    #1;
    chk("b_t255", 64'(in_bvalid), 64'd0);
    tick();
    #1;
    chk("b_t0", 64'(in_bvalid), 64'd0);
    tick();
    #1;
    chk("b_t1", 64'(in_bvalid), 64'd1);
    chk("b_id", 64'(in_bid), 64'h5);
    chk("b_resp", 64'(in_bresp), 64'h2);
    stable = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      #1;
      if (in_bvalid === 1'b1 && in_bid === 4'h5 && in_bresp === 2'b10) stable++;
    end
    chk("b_hold", 64'(stable), 64'd300);
    in_bready = 1'b1;
    tick();
    in_bready = 1'b0;
    #1;
    chk("b_popped", 64'(in_bvalid), 64'd0);

    // Reset with beats pending plus one offered during the reset cycle
    out_rvalid = 1'b1; out_rid = 4'h1; out_rdata = 32'hC000_0000;
    tick();
    out_rdata = 32'hC000_0001;
    tick();
    out_rvalid = 1'b0;
    out_bvalid = 1'b1; out_bid = 4'h6; out_bresp = 2'b01;
    tick();
    out_bvalid = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("pre_rst_r", 64'(in_rvalid), 64'd1);
    chk("pre_rst_b", 64'(in_bvalid), 64'd1);
    reset = 1'b1; out_rvalid = 1'b1; out_rdata = 32'hC000_0002;
    tick();
    reset = 1'b0; out_rvalid = 1'b0;
    tmr   = 8'd0;
    #1;
    chk("post_rst_rvalid", 64'(in_rvalid), 64'd0);
    chk("post_rst_bvalid", 64'(in_bvalid), 64'd0);
    chk("post_rst_rready", 64'(out_rready), 64'd1);
    chk("post_rst_bready", 64'(out_bready), 64'd1);
    in_rready = 1'b1; in_bready = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      #1;
      if (in_rvalid || in_bvalid) seen++;
    end
    chk("no_stale", 64'(seen), 64'd0);

    // Bypass instance: same-cycle wires
    out_rvalid = 1'b1; out_rid = 4'h9; out_rdata = 32'h1234_5678; out_rlast = 1'b1;
    out_bvalid = 1'b1; out_bresp = 2'b01; in_rready = 1'b1;
    #1;
    chk("byp_rvalid", 64'(x_in_rvalid), 64'd1);
    chk("byp_rdata", 64'(x_in_rdata), 64'h1234_5678);
    chk("byp_rid", 64'(x_in_rid), 64'h9);
    chk("byp_rready", 64'(x_out_rready), 64'd1);
    chk("byp_bvalid", 64'(x_in_bvalid), 64'd1);
    chk("byp_bresp", 64'(x_in_bresp), 64'h1);
    out_rvalid = 1'b0; out_bvalid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_timed_delayer.md
AXI4_TIMED_DELAYER -- requirements
Module: axi4_timed_delayer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning R data width (bits).
REQ-002 SHALL have parameter ID_W, default 4, meaning AR/AW/R/B ID width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning R and B buffer entries each; power of 2, at least 2.
REQ-004 SHALL have parameter DELAY, default 3, meaning response delay in cycles; legal range 1..2^(CNT_W-1)-1.
REQ-005 SHALL have parameter CNT_W, default 8, meaning timer width.
REQ-006 SHALL have parameter BYPASS, default 0, meaning that 1 makes R/B pure wires, identical to AR/AW/W.
REQ-007 SHALL have port clock, input, width 1, the single clock; all state is updated on its rising edge.
REQ-008 SHALL have port reset, input, width 1, synchronous active-high reset.
REQ-009 SHALL have ports in_ar*/out_ar* (valid, ready, id ID_W, addr 32, len 8, size 3, burst 2), the AR channel, upstream/downstream.
REQ-010 SHALL have ports in_aw*/out_aw*, the AW channel, same field set as AR.
REQ-011 SHALL have ports in_w*/out_w* (valid, ready, data DATA_W, strb DATA_W/8, last), the W channel.
REQ-012 SHALL have ports in_r*/out_r* (valid, ready, id, data DATA_W, resp 2, last), the R channel.
REQ-013 SHALL have ports in_b*/out_b* (valid, ready, id, resp 2), the B channel.

Function
REQ-014 AR, AW and W SHALL pass through combinationally in both directions, with zero latency and no state.
REQ-015 Timer SHALL be a free-running CNT_W counter that increments every cycle and wraps modulo 2^CNT_W.
REQ-016 An out_rvalid&&out_rready handshake in cycle t SHALL push {id,data,resp,last,stamp=timer_t+DELAY mod 2^CNT_W} into the R FIFO.
REQ-017 The head entry SHALL become eligible when (timer-stamp) mod 2^CNT_W < 2^(CNT_W-1); eligibility SHALL be sticky until pop.
REQ-018 in_rvalid SHALL be 1 only when the FIFO is non-empty and the head is eligible; a beat accepted in cycle t SHALL first appear in cycle t+DELAY.
REQ-019 Once in_rvalid=1, it and the payload SHALL hold stable until in_rready, regardless of stall length or timer wrap.
REQ-020 Pop SHALL occur on in_rvalid&&in_rready; order SHALL be strictly FIFO, with no reordering by ID.
REQ-021 out_rready SHALL equal !full; a same-cycle pop SHALL NOT open a slot in that cycle.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 The B channel SHALL behave identically (REQ-016..022) with payload {id,resp} and an independent FIFO.
REQ-024 A pop in cycle t SHALL let the next head, if already eligible, assert in_rvalid/in_bvalid in cycle t+1; throughput SHALL be 1 beat/cycle.
REQ-025 With BYPASS=1, in_r*/in_b* SHALL be wired directly to out_r*/out_b* and the FIFOs, timer and flags SHALL be absent.

Reset
REQ-026 On reset, timer, pointers, counts and eligibility flags SHALL be 0; buffered entries SHALL be discarded, and payload RAM need not reset.
REQ-027 In the cycle after reset, outputs SHALL be: in_rvalid=0, in_bvalid=0, out_rready=1, out_bready=1.
REQ-028 Reset asserted mid-burst SHALL drop all pending beats, with no partial beat emitted afterwards.

Structure
REQ-029 Package axi4_delayer_pkg SHALL hold the R and B entry structs and the localparams PTR_W=$clog2(DEPTH) and HALF=2^(CNT_W-1).
REQ-030 Sub-module delay_fifo (generic payload width, DEPTH, CNT_W, DELAY) SHALL hold storage, pointers, stamp compare and sticky flag; the top instantiates it twice and owns the timer.

Verification (DELAY=3, DEPTH=4, CNT_W=8)
REQ-031 Single R beat id=2, data=0xDEADBEEF, last=1, accepted at cycle 10 -> in_rvalid first 1 at cycle 13 with identical payload.
REQ-032 4-beat burst accepted in cycles 20-23, in_rready=1 -> beats appear in cycles 23-26 in order, rlast on the 4th only.
REQ-033 in_rready=0, 5 beats offered -> out_rready=0 after the 4th accept; 5th held; release order 1..5 after in_rready=1.
REQ-034 B beat accepted at timer=254 -> stamp=1; in_bvalid at timer=1; then in_bready=0 for 300 cycles -> in_bvalid and payload stable throughout.
REQ-035 Reset pulse with 2 R and 1 B pending -> next cycle in_rvalid=in_bvalid=0, out_rready=out_bready=1, no stale beat afterwards.
REQ-036 BYPASS=1, out_rvalid=1 with data=0x12345678 -> in_rvalid=1 and in_rdata=0x12345678 in the same cycle.
